// File: rtl/ft245_pkg.sv
// ft245_pkg
// Shared definitions for the FT245 out-FIFO arbiter slice.
//   arb_state_t : arbiter FSM encoding (ARB_IDLE / ARB_XFER)
//   GRANT_W     : width of grant index / round-robin pointer (up to 4 sources)
package ft245_pkg;

  localparam int GRANT_W = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ft245_rr_pick.sv
// ft245_rr_pick
// Combinational round-robin picker: returns the first requesting index
// strictly after the pointer, wrapping modulo NUM_REQ.  Because the search
// starts one past the pointer, the pointer's own index is considered last.
// Ports:
//   req  in  NUM_REQ   request vector
//   ptr  in  GRANT_W   index of the previous winner
//   any  out 1         at least one request present
//   idx  out GRANT_W   winning index (0 when no request)
module ft245_rr_pick
  import ft245_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               any,
  output logic [GRANT_W-1:0] idx
);

  // Scan from the farthest candidate back to the nearest so that the
  // nearest requester after the pointer is the last (winning) assignment.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (((int'(ptr) + k) % NUM_REQ) == j && req[j]) begin
          idx = GRANT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ft245_out_arbiter.sv
// ft245_out_arbiter
// Packet-atomic round-robin arbiter sharing the FT245 sync FIFO out-FIFO
// write port among NUM_REQ byte sources.  A granted source keeps the port
// until its last byte; a watchdog releases a source that stalls mid-packet.
// Ports:
//   clk, rst_n        host clock, async active-low reset
//   req_valid/last    per-source byte valid and last-of-packet marker
//   req_data          per-source byte, source i at [8*i+7:8*i]
//   req_ready         per-source accept (valid & ready = byte taken)
//   out_fifo_wr/data  write strobe and byte to the out FIFO
//   out_fifo_full     out FIFO full, blocks writes
//   grant_idx         current / most recent granted source
//   busy              packet in progress
//   wd_abort          one-cycle pulse after a watchdog release
//   byte_count        free-running count of bytes written (wraps)
module ft245_out_arbiter
  import ft245_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int WD_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_fifo_wr,
  output logic [7:0]           out_fifo_data,
  input  logic                 out_fifo_full,
  output logic [GRANT_W-1:0]   grant_idx,
  output logic                 busy,
  output logic                 wd_abort,
  output logic [15:0]          byte_count
);

  localparam logic [7:0] WD_LAST = 8'(WD_CYCLES - 1);

  arb_state_t         state, state_nxt;
  logic [GRANT_W-1:0] rr_ptr;
  logic [7:0]         wd_cnt;
  logic               pick_any;
  logic [GRANT_W-1:0] pick_idx;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic               wd_fire;
  logic               idle_tick;

  ft245_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Route the granted source's valid/last/data onto a single set of wires.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == GRANT_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // Stalls caused by a full FIFO are not the source's fault, so only
  // source-idle cycles with room in the FIFO feed the watchdog.
  assign idle_tick = (state == ARB_XFER) && !sel_valid && !out_fifo_full;

  // Next state and the combinational write-port outputs.  Nothing is
  // accepted in IDLE, which gives the one-cycle arbitration bubble.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    out_fifo_wr   = 1'b0;
    out_fifo_data = 8'h00;
    wd_fire       = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) state_nxt = ARB_XFER;
      end
      ARB_XFER: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_idx == GRANT_W'(i)) req_ready[i] = !out_fifo_full;
        end
        out_fifo_wr   = sel_valid && !out_fifo_full;
        out_fifo_data = out_fifo_wr ? sel_data : 8'h00;
        wd_fire       = idle_tick && (wd_cnt == WD_LAST);
        if ((out_fifo_wr && sel_last) || wd_fire) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Grant and round-robin pointer update only when a new packet is granted;
  // grant_idx therefore holds the last winner while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx <= '0;
      rr_ptr    <= GRANT_W'(NUM_REQ - 1);
    end else if (state == ARB_IDLE && pick_any) begin
      grant_idx <= pick_idx;
      rr_ptr    <= pick_idx;
    end
  end

  // Byte counter, watchdog counter and the registered abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt     <= 8'h00;
      byte_count <= 16'h0000;
      wd_abort   <= 1'b0;
    end else begin
      wd_abort <= wd_fire;
      if (out_fifo_wr) begin
        byte_count <= byte_count + 16'd1;
        wd_cnt     <= 8'h00;
      end else if (idle_tick) begin
        wd_cnt <= wd_fire ? 8'h00 : wd_cnt + 8'd1;
      end else if (state == ARB_IDLE) begin
        wd_cnt <= 8'h00;
      end
    end
  end

  assign busy = (state == ARB_XFER);

endmodule

// File: tb/tb_ft245_out_arbiter.sv
// tb_ft245_out_arbiter
// Sources are byte queues; expected output bytes are queued per source when
// a packet is created and popped by the monitor whenever the DUT writes.
// A packet-level reference model (grant choice, atomic packets, watchdog
// idle counting, byte total) predicts every output each cycle.
module tb_ft245_out_arbiter;

  localparam int N  = 3;
  localparam int WD = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           out_fifo_wr;
  logic [7:0]     out_fifo_data;
  logic           out_fifo_full = 1'b0;
  logic [1:0]     grant_idx;
  logic           busy;
  logic           wd_abort;
  logic [15:0]    byte_count;

  ft245_out_arbiter #(.NUM_REQ(N), .WD_CYCLES(WD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .out_fifo_wr   (out_fifo_wr),
    .out_fifo_data (out_fifo_data),
    .out_fifo_full (out_fifo_full),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .wd_abort      (wd_abort),
    .byte_count    (byte_count)
  );

  always #5 clk = ~clk;

  logic [8:0] src_q[N][$];
  logic [8:0] exp_q[N][$];
  int  total = 0;
  int  bad = 0;
  bit  hold[N];
  int  valid_pct = 100;
  int  full_pct = 0;
  bit  force_full = 1'b0;
  int  abort_seen = 0;
  int  grant_log[$];

  bit          m_busy = 1'b0;
  int          m_g = 0;
  int          m_ptr = N - 1;
  int          m_cnt = 0;
  logic [15:0] m_bc = 16'h0;
  bit          m_abort = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addPacket(input int src, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      src_q[src].push_back({k == len - 1, 8'(base + k)});
      exp_q[src].push_back({k == len - 1, 8'(base + k)});
    end
  endtask

  task automatic applyStimulus(input int vpct, input int fpct, input int cycles);
    valid_pct = vpct;
    full_pct  = fpct;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while ((pending() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput({tag, "_drain_in_budget"}, 32'(n < budget), 32'd1);
    @(posedge clk);
    #2;
  endtask

  // Source driver: present the front byte of each source queue after every edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i] && $urandom_range(99) < valid_pct) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    out_fifo_full = force_full || ($urandom_range(99) < full_pct);
  end

  // Monitor: predict, compare, pop the scoreboard, then advance the model.
  always @(negedge clk) begin
    logic       exp_wr;
    logic [N-1:0] exp_ready;
    logic [7:0] exp_data;
    logic [8:0] ent;
    int         pick;
    bit         nxt_abort;
    if (!rst_n) begin
      m_busy = 1'b0; m_g = 0; m_ptr = N - 1; m_cnt = 0; m_bc = 16'h0; m_abort = 1'b0;
    end
    exp_wr    = m_busy && req_valid[m_g] && !out_fifo_full;
    exp_ready = '0;
    if (m_busy && !out_fifo_full) exp_ready[m_g] = 1'b1;
    exp_data  = 8'h00;
    if (out_fifo_wr) begin
      if (exp_q[m_g].size() == 0) begin
        checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        ent = exp_q[m_g].pop_front();
        exp_data = ent[7:0];
      end
    end
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("grant_idx", 32'(grant_idx), 32'(m_g));
    checkOutput("out_fifo_wr", 32'(out_fifo_wr), 32'(exp_wr));
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("out_fifo_data", 32'(out_fifo_data), 32'(exp_data));
    checkOutput("wd_abort", 32'(wd_abort), 32'(m_abort));
    checkOutput("byte_count", 32'(byte_count), 32'(m_bc));
    if (wd_abort) abort_seen++;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    if (rst_n) begin
      nxt_abort = 1'b0;
      if (!m_busy) begin
        pick = -1;
        for (int k = 1; k <= N; k++) begin
          if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        end
        if (pick >= 0) begin
          m_g = pick; m_ptr = pick; m_busy = 1'b1;
          grant_log.push_back(pick);
        end
      end else if (!out_fifo_full) begin
        if (req_valid[m_g]) begin
          m_bc  = m_bc + 16'd1;
          m_cnt = 0;
          if (req_last[m_g]) m_busy = 1'b0;
        end else begin
          m_cnt++;
          if (m_cnt == WD) begin
            m_busy = 1'b0; m_cnt = 0; nxt_abort = 1'b1;
          end
        end
      end
      m_abort = nxt_abort;
    end
  end

  initial begin
    int guard;
    int abort0;
    logic [15:0] bc0;
    logic [15:0] bcf;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(100, 0, 2);

    // Four-byte packet from source 0 after reset.
    $display("[TB] single source packet");
    grant_log.delete();
    addPacket(0, 4, 8'hA0);
    waitDrain("t2", 50);
    checkOutput("t2_byte_count", 32'(byte_count), 32'd4);
    checkOutput("t2_grants", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() > 0) checkOutput("t2_grant0", 32'(grant_log[0]), 32'd0);

    // Reset asserted in the middle of a packet.
    $display("[TB] reset mid-packet");
    addPacket(1, 10, 8'h10);
    guard = 0;
    while (!(busy && byte_count > 16'd5) && guard < 50) begin @(posedge clk); #2; guard++; end
    checkOutput("t1_reached_xfer", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_wr", 32'(out_fifo_wr), 32'd0);
    checkOutput("t1_ready", 32'(req_ready), 32'd0);
    checkOutput("t1_grant", 32'(grant_idx), 32'd0);
    checkOutput("t1_byte_count", 32'(byte_count), 32'd0);
    for (int i = 0; i < N; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(100, 0, 2);

    // Two sources contending: packets alternate starting from source 0.
    $display("[TB] round robin");
    grant_log.delete();
    addPacket(0, 3, 8'h20);
    addPacket(0, 3, 8'h28);
    addPacket(1, 3, 8'h30);
    waitDrain("t3", 60);
    checkOutput("t3_grants", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      checkOutput("t3_grant0", 32'(grant_log[0]), 32'd0);
      checkOutput("t3_grant1", 32'(grant_log[1]), 32'd1);
      checkOutput("t3_grant2", 32'(grant_log[2]), 32'd0);
    end

    // Long full stall mid-packet must not trip the watchdog.
    $display("[TB] full stall");
    abort0 = abort_seen;
    bc0 = byte_count;
    addPacket(2, 6, 8'h50);
    guard = 0;
    while (src_q[2].size() > 4 && guard < 50) begin @(posedge clk); guard++; end
    force_full = 1'b1;
    #2;
    bcf = byte_count;
    repeat (300) @(posedge clk);
    #2;
    checkOutput("t4_no_writes", 32'(byte_count), 32'(bcf));
    checkOutput("t4_still_busy", 32'(busy), 32'd1);
    checkOutput("t4_no_abort", 32'(abort_seen), 32'(abort0));
    force_full = 1'b0;
    waitDrain("t4", 60);
    checkOutput("t4_total", 32'(byte_count), 32'(16'(bc0 + 16'd6)));

    // Source 1 stalls after two bytes; watchdog hands the port to source 0.
    $display("[TB] watchdog");
    abort0 = abort_seen;
    addPacket(1, 5, 8'h70);
    guard = 0;
    while (src_q[1].size() > 3 && guard < 50) begin @(posedge clk); guard++; end
    hold[1] = 1'b1;
    addPacket(0, 2, 8'h90);
    applyStimulus(100, 0, 14);
    checkOutput("t5_abort_once", 32'(abort_seen), 32'(abort0 + 1));
    checkOutput("t5_src0_granted", 32'(grant_log[grant_log.size()-1]), 32'd0);
    hold[1] = 1'b0;
    waitDrain("t5", 60);

    // Random traffic with valid gaps and full back-pressure.
    $display("[TB] random traffic");
    for (int p = 0; p < 40; p++) begin
      addPacket($urandom_range(N - 1), $urandom_range(6, 1), 8'($urandom));
    end
    valid_pct = 70;
    full_pct  = 20;
    waitDrain("rand", 4000);
    valid_pct = 100;
    full_pct  = 0;

    // One long packet pushes byte_count through its wrap point.
    $display("[TB] byte_count wrap");
    bc0 = byte_count;
    addPacket(2, 65540, 8'h00);
    waitDrain("wrap", 66000);
    checkOutput("wrap_total", 32'(byte_count), 32'(16'(bc0 + 16'd65540)));

    for (int i = 0; i < N; i++) checkOutput("scoreboard_leftover", 32'(exp_q[i].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
